// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART bus bridge: register map, status layout and TX FSM states.
package uart_bus_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_CLKDIV = 2'd2;

    localparam int unsigned STAT_TX_FULL    = 0;
    localparam int unsigned STAT_TX_EMPTY   = 1;
    localparam int unsigned STAT_RX_EMPTY   = 2;
    localparam int unsigned STAT_RX_FULL    = 3;
    localparam int unsigned STAT_RX_OVERRUN = 4;
    localparam int unsigned STAT_FRAME_ERR  = 5;
    localparam int unsigned STAT_TX_BUSY    = 6;

    // Field order matches the STATUS bit indices above (MSB = tx_busy).
    typedef struct packed {
        logic tx_busy;
        logic frame_err;
        logic rx_overrun;
        logic rx_full;
        logic rx_empty;
        logic tx_empty;
        logic tx_full;
    } status_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_ACK   = 2'd2,
        T_DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// CPU-side register bus of the UART bridge.
interface uart_bus_bridge_if;
    import uart_bus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              irq;

    modport master (output addr, wr_en, rd_en, data_in, input data_out, irq);
    modport slave  (input addr, wr_en, rd_en, data_in, output data_out, irq);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_next;

    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || pop);
        count_next = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count_next;
            full   <= (count_next == CW'(DEPTH));
            empty  <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/uart_bus_bridge.sv
// Memory-mapped front end for the UART core: TX/RX FIFOs, sticky error flags and baud divisor.
module uart_bus_bridge
    import uart_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter logic [15:0] CLK_DIV_RESET = 16'd1302
) (
    input  logic                clk,
    input  logic                rst,
    uart_bus_bridge_if.slave    bus,
    output logic                uart_transmit,
    output logic [7:0]          uart_tx_byte,
    input  logic                uart_is_transmitting,
    input  logic                uart_received,
    input  logic [7:0]          uart_rx_byte,
    input  logic                uart_recv_error,
    output logic [15:0]         uart_clk_div
);
    tx_state_t                 state;
    logic [15:0]               clkdiv;
    logic                      rx_overrun;
    logic                      frame_err;
    logic [7:0]                tx_head;
    logic [7:0]                rx_head;
    logic                      tx_full, tx_empty, rx_full, rx_empty;
    logic [$clog2(FIFO_DEPTH):0] tx_count, rx_count;
    logic                      wr_data, wr_status, wr_clkdiv, rd_data;
    logic                      tx_pop, rx_pop, ovr_set;
    status_t                   status;
    logic                      unused_counts;

    always_comb begin
        wr_data   = bus.wr_en && (bus.addr == ADDR_DATA);
        wr_status = bus.wr_en && (bus.addr == ADDR_STATUS);
        wr_clkdiv = bus.wr_en && (bus.addr == ADDR_CLKDIV);
        rd_data   = bus.rd_en && (bus.addr == ADDR_DATA);
        rx_pop    = rd_data && !rx_empty;
        tx_pop    = (state == T_START);
        ovr_set   = uart_received && rx_full && !rx_pop;
        status    = '{tx_busy:    (state != T_IDLE) || uart_is_transmitting,
                      frame_err:  frame_err,
                      rx_overrun: rx_overrun,
                      rx_full:    rx_full,
                      rx_empty:   rx_empty,
                      tx_empty:   tx_empty,
                      tx_full:    tx_full};
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(wr_data), .pop(tx_pop), .wdata(bus.data_in[7:0]),
        .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(uart_received), .pop(rx_pop), .wdata(uart_rx_byte),
        .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    assign unused_counts = ^{tx_count, rx_count};

    // Register file, sticky flags (set beats clear), read data and irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkdiv       <= CLK_DIV_RESET;
            rx_overrun   <= 1'b0;
            frame_err    <= 1'b0;
            bus.data_out <= '0;
            bus.irq      <= 1'b0;
        end else begin
            if (wr_clkdiv) clkdiv <= bus.data_in;
            rx_overrun <= ovr_set ||
                          (rx_overrun && !(wr_status && bus.data_in[STAT_RX_OVERRUN]));
            frame_err  <= uart_recv_error ||
                          (frame_err && !(wr_status && bus.data_in[STAT_FRAME_ERR]));
            bus.irq    <= !rx_empty || rx_overrun || frame_err;
            if (bus.rd_en) begin
                case (bus.addr)
                    ADDR_DATA:   bus.data_out <= rx_empty ? 16'h0000 : {8'h00, rx_head};
                    ADDR_STATUS: bus.data_out <= {9'b0, status};
                    ADDR_CLKDIV: bus.data_out <= clkdiv;
                    default:     bus.data_out <= 16'h0000;
                endcase
            end
        end
    end

    // TX handshake: never starts a byte while the UART still reports busy, including after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= T_IDLE;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
        end else begin
            uart_transmit <= 1'b0;
            case (state)
                T_IDLE: begin
                    if (!tx_empty && !uart_is_transmitting) begin
                        state         <= T_START;
                        uart_transmit <= 1'b1;
                        uart_tx_byte  <= tx_head;
                    end
                end
                T_START: state <= T_ACK;
                T_ACK:   if (uart_is_transmitting)  state <= T_DONE;
                T_DONE:  if (!uart_is_transmitting) state <= T_IDLE;
                default: state <= T_IDLE;
            endcase
        end
    end

    assign uart_clk_div = clkdiv;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed self-checking bench for uart_bus_bridge with a simple busy-for-40-cycles UART model.
module tb_uart_bus_bridge;
    import uart_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;
    logic       uart_received;
    logic [7:0] uart_rx_byte;
    logic       uart_recv_error;
    logic [15:0] uart_clk_div;

    uart_bus_bridge_if bus();

    uart_bus_bridge #(.FIFO_DEPTH(8), .CLK_DIV_RESET(16'd1302)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_is_transmitting(uart_is_transmitting),
        .uart_received(uart_received), .uart_rx_byte(uart_rx_byte),
        .uart_recv_error(uart_recv_error), .uart_clk_div(uart_clk_div)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;
    logic hold_busy = 1'b0;
    int   cyc = 0;
    int   pulses_busy = 0;
    logic [7:0] tx_log [$];
    int         pulse_t [$];

    assign uart_is_transmitting = (busy_cnt != 0) || hold_busy;

    // UART model: busy from the cycle after a start pulse, for 40 cycles; logs every pulse.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_transmit) begin
            busy_cnt <= 40;
            tx_log.push_back(uart_tx_byte);
            pulse_t.push_back(cyc);
            if (uart_is_transmitting) pulses_busy <= pulses_busy + 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.addr = a; bus.data_in = d; bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.addr = a; bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        d = bus.data_out;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        for (int i = 0; i < budget && tx_log.size() < n; i++) @(negedge clk);
        check("tx_pulse_count", 16'(tx_log.size()), 16'(n));
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] rd;

        vecs[0] = '{wr: 1'b0, addr: ADDR_STATUS, data: 16'h0000, exp: 16'h0006};
        vecs[1] = '{wr: 1'b0, addr: ADDR_CLKDIV, data: 16'h0000, exp: 16'd1302};
        vecs[2] = '{wr: 1'b0, addr: 2'd3,        data: 16'h0000, exp: 16'h0000};
        vecs[3] = '{wr: 1'b0, addr: ADDR_DATA,   data: 16'h0000, exp: 16'h0000};
        vecs[4] = '{wr: 1'b1, addr: 2'd3,        data: 16'hFFFF, exp: 16'h0000};
        vecs[5] = '{wr: 1'b0, addr: ADDR_STATUS, data: 16'h0000, exp: 16'h0006};
        vecs[6] = '{wr: 1'b1, addr: ADDR_CLKDIV, data: 16'h1234, exp: 16'h0000};
        vecs[7] = '{wr: 1'b0, addr: ADDR_CLKDIV, data: 16'h0000, exp: 16'h1234};

        rst = 1'b1;
        bus.addr = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
        uart_received = 1'b0; uart_rx_byte = '0; uart_recv_error = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_data_out", bus.data_out, 16'h0000);
        check("reset_irq", 16'(bus.irq), 16'h0000);
        check("reset_transmit", 16'(uart_transmit), 16'h0000);
        check("reset_tx_byte", 16'(uart_tx_byte), 16'h0000);
        check("reset_clk_div", uart_clk_div, 16'd1302);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_read", i), rd, vecs[i].exp);
            end
        end
        check("no_pulse_idle", 16'(tx_log.size()), 16'h0000);

        // Two back-to-back DATA writes
        @(negedge clk);
        bus.addr = ADDR_DATA; bus.data_in = 16'h0041; bus.wr_en = 1'b1;
        @(negedge clk);
        bus.data_in = 16'h0042;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_pulses(2, 300);
        repeat (50) @(negedge clk);
        check("tx_two_count", 16'(tx_log.size()), 16'd2);
        check("tx_byte0", 16'(tx_log[0]), 16'h0041);
        check("tx_byte1", 16'(tx_log[1]), 16'h0042);
        check("tx_gap_after_busy", 16'(pulse_t[1] - pulse_t[0] > 40), 16'd1);
        check("tx_pulse_while_busy", 16'(pulses_busy), 16'd0);
        bus_read(ADDR_STATUS, rd);
        check("tx_drained_status", rd, 16'h0006);

        // Fill TX FIFO with UART held busy: 8 accepted, 2 dropped
        tx_log.delete(); pulse_t.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 10; i++) bus_write(ADDR_DATA, 16'(16'h0050 + i));
        bus_read(ADDR_STATUS, rd);
        check("tx_full_status", rd, 16'h0045);
        check("tx_none_while_held", 16'(tx_log.size()), 16'd0);
        hold_busy = 1'b0;
        wait_pulses(8, 2000);
        repeat (100) @(negedge clk);
        check("tx_overflow_count", 16'(tx_log.size()), 16'd8);
        for (int i = 0; i < 8 && i < tx_log.size(); i++)
            check($sformatf("tx_fill_byte%0d", i), 16'(tx_log[i]), 16'(16'h0050 + i));
        check("tx_fill_pulse_while_busy", 16'(pulses_busy), 16'd0);

        // RX overrun: 9 bytes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            uart_received = 1'b1; uart_rx_byte = 8'(i);
            @(negedge clk);
            uart_received = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rx_irq_set", 16'(bus.irq), 16'd1);
        bus_read(ADDR_STATUS, rd);
        check("rx_full_status", rd, 16'h001A);
        for (int i = 0; i < 9; i++) begin
            bus_read(ADDR_DATA, rd);
            check($sformatf("rx_read%0d", i), rd, (i < 8) ? 16'(i) : 16'h0000);
        end
        bus_read(ADDR_STATUS, rd);
        check("rx_drained_status", rd, 16'h0016);
        bus_write(ADDR_STATUS, 16'h0010);
        repeat (2) @(negedge clk);
        check("rx_irq_clear", 16'(bus.irq), 16'd0);
        bus_read(ADDR_STATUS, rd);
        check("rx_overrun_clear", rd, 16'h0006);

        // Framing error set wins over a same-cycle clear
        @(negedge clk);
        bus.addr = ADDR_STATUS; bus.data_in = 16'h0020; bus.wr_en = 1'b1; uart_recv_error = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0; uart_recv_error = 1'b0;
        bus_read(ADDR_STATUS, rd);
        check("frame_err_set_wins", rd, 16'h0026);
        check("frame_err_irq", 16'(bus.irq), 16'd1);
        bus_write(ADDR_STATUS, 16'h0020);
        bus_read(ADDR_STATUS, rd);
        check("frame_err_clear", rd, 16'h0006);

        // Divisor update
        bus_write(ADDR_CLKDIV, 16'h0036);
        check("clk_div_out", uart_clk_div, 16'h0036);
        bus_read(ADDR_CLKDIV, rd);
        check("clk_div_read", rd, 16'h0036);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
